// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO: default geometry, pointer typedefs,
// read-side output FSM encoding and binary-to-gray helper.
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

  typedef logic [FIFO_AW:0]   ptr_t;
  typedef logic [FIFO_AW-1:0] addr_t;

  typedef enum logic {
    EMPTY_OUT = 1'b0,
    VALID_OUT = 1'b1
  } rd_state_e;

  // Width-agnostic: callers truncate the result to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Purely combinational gray-to-binary converter; each binary bit is the XOR
// of all gray bits at or above its position.
module gray2bin #(
  parameter int N = 5
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side control of the async FIFO: read pointer, empty flag, occupancy and
// FWFT output register. Optional almost_empty output under FIFO_RD_ALMOST_EMPTY_EN.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  , parameter int AE_LEVEL = 2
`endif
  , localparam int AW = $clog2(DEPTH)
) (
  input  logic             r_clk,
  input  logic             rst_n,
  input  logic [AW:0]      rsync_ptr2,
  input  logic [WIDTH-1:0] rdata_mem,
  output logic [AW-1:0]    raddr,
  output logic [AW:0]      rptr,
  output logic             empty,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [AW:0]      rd_count
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  , output logic           almost_empty
`endif
);

  logic [AW:0]      rbin_r;
  logic [AW:0]      rptr_r;
  logic             empty_r;
  logic [AW:0]      count_r;
  logic [WIDTH-1:0] dout_r;
  rd_state_e        state_r;

  logic [AW:0]      rbin_next_s;
  logic [AW:0]      rgray_next_s;
  logic [AW:0]      wbin_sync_s;
  logic [AW:0]      count_next_s;
  logic             pop_s;
  rd_state_e        state_next_s;
  logic [WIDTH-1:0] dout_next_s;

  gray2bin #(.N(AW + 1)) u_wptr_g2b (
    .gray (rsync_ptr2),
    .bin  (wbin_sync_s)
  );

  // Pointer arithmetic: a word leaves memory whenever the output register can take it.
  always_comb begin
    pop_s        = ~empty_r & (~dout_valid | dout_ready);
    rbin_next_s  = rbin_r + (AW + 1)'(pop_s);
    rgray_next_s = (AW + 1)'(bin2gray(32'(rbin_next_s)));
    count_next_s = wbin_sync_s - rbin_next_s;
  end

  // Pointer, empty flag and occupancy registers.
  always_ff @(posedge r_clk or posedge rst_n) begin
    if (rst_n) begin
      rbin_r  <= '0;
      rptr_r  <= '0;
      empty_r <= 1'b1;
      count_r <= '0;
    end else begin
      rbin_r  <= rbin_next_s;
      rptr_r  <= rgray_next_s;
      empty_r <= (rgray_next_s == rsync_ptr2);
      count_r <= count_next_s;
    end
  end

  // Output FSM next state; a pop in VALID_OUT only happens when dout_ready is high.
  always_comb begin
    state_next_s = state_r;
    dout_next_s  = dout_r;
    case (state_r)
      EMPTY_OUT: begin
        if (pop_s) begin
          dout_next_s  = rdata_mem;
          state_next_s = VALID_OUT;
        end else begin
          state_next_s = EMPTY_OUT;
        end
      end
      VALID_OUT: begin
        if (pop_s) begin
          dout_next_s  = rdata_mem;
          state_next_s = VALID_OUT;
        end else if (dout_ready) begin
          state_next_s = EMPTY_OUT;
        end else begin
          state_next_s = VALID_OUT;
        end
      end
      default: begin
        state_next_s = EMPTY_OUT;
      end
    endcase
  end

  // Output FSM state and data register.
  always_ff @(posedge r_clk or posedge rst_n) begin
    if (rst_n) begin
      state_r <= EMPTY_OUT;
      dout_r  <= '0;
    end else begin
      state_r <= state_next_s;
      dout_r  <= dout_next_s;
    end
  end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic ae_r;

  // Almost-empty threshold uses the same next-cycle occupancy as rd_count.
  always_ff @(posedge r_clk or posedge rst_n) begin
    if (rst_n) begin
      ae_r <= 1'b1;
    end else begin
      ae_r <= (count_next_s <= (AW + 1)'(AE_LEVEL));
    end
  end

  assign almost_empty = ae_r;
`endif

  assign raddr      = rbin_r[AW-1:0];
  assign rptr       = rptr_r;
  assign empty      = empty_r;
  assign rd_count   = count_r;
  assign dout       = dout_r;
  assign dout_valid = (state_r == VALID_OUT);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with an asynchronous-read memory model;
// covers almost_empty when FIFO_RD_ALMOST_EMPTY_EN is defined.
module tb_fifo_rd_ctrl;

  logic       r_clk;
  logic       rst_n;
  logic [4:0] rsync_ptr2;
  logic [7:0] rdata_mem;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       empty;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [4:0] rd_count;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic       almost_empty;
`endif

  logic [7:0] mem [0:15];
  int n_checks;
  int n_fail;

  assign rdata_mem = mem[raddr];

  fifo_rd_ctrl #(.WIDTH(8), .DEPTH(16)) dut (
    .r_clk      (r_clk),
    .rst_n      (rst_n),
    .rsync_ptr2 (rsync_ptr2),
    .rdata_mem  (rdata_mem),
    .raddr      (raddr),
    .rptr       (rptr),
    .empty      (empty),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .rd_count   (rd_count)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    , .almost_empty (almost_empty)
`endif
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b1;
    rsync_ptr2 = 5'b00000;
    dout_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsync_ptr2 = 5'b00000; dout_ready = 1'b1;
    #3;
    rst_n = 1'b1;
    #1;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b exp 1", empty); end
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", dout_valid); end
    n_checks++; if (rptr !== 5'b00000) begin n_fail++; $display("FAIL reset_rptr got %b exp 00000", rptr); end
    n_checks++; if (raddr !== 4'd0) begin n_fail++; $display("FAIL reset_raddr got %0d exp 0", raddr); end
    n_checks++; if (rd_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", rd_count); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h exp 00", dout); end
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae got %0b exp 1", almost_empty); end
`endif
    tick();
    rst_n = 1'b0;
    tick();
    n_checks++; if (empty !== 1'b1 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset got empty=%0b valid=%0b exp 1/0", empty, dout_valid); end
  endtask

  task automatic test_single_word();
    do_reset();
    mem[0] = 8'hA5;
    rsync_ptr2 = 5'b00001;
    tick();
    n_checks++; if (empty !== 1'b0 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL single_edge1 got empty=%0b valid=%0b exp 0/0", empty, dout_valid); end
    n_checks++; if (rd_count !== 5'd1) begin n_fail++; $display("FAIL single_count1 got %0d exp 1", rd_count); end
    tick();
    n_checks++; if (dout_valid !== 1'b1 || dout !== 8'hA5) begin n_fail++; $display("FAIL single_dout got valid=%0b dout=%h exp 1/a5", dout_valid, dout); end
    n_checks++; if (rptr !== 5'b00001 || raddr !== 4'd1) begin n_fail++; $display("FAIL single_ptr got rptr=%b raddr=%0d exp 00001/1", rptr, raddr); end
    n_checks++; if (empty !== 1'b1 || rd_count !== 5'd0) begin n_fail++; $display("FAIL single_empty got empty=%0b count=%0d exp 1/0", empty, rd_count); end
    tick();
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL single_consumed got %0b exp 0", dout_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    dout_ready = 1'b0;
    rsync_ptr2 = 5'b00010;
    tick();
    tick();
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (dout_valid !== 1'b1 || dout !== 8'h11) begin n_fail++; $display("FAIL bp_hold got valid=%0b dout=%h exp 1/11", dout_valid, dout); end
    n_checks++; if (raddr !== 4'd1) begin n_fail++; $display("FAIL bp_raddr got %0d exp 1", raddr); end
    n_checks++; if (rd_count !== 5'd2) begin n_fail++; $display("FAIL bp_count got %0d exp 2", rd_count); end
    dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dout_valid !== 1'b1 || dout !== mem[i]) begin
        n_fail++; $display("FAIL bp_word%0d got valid=%0b dout=%h exp 1/%h", i, dout_valid, dout, mem[i]);
      end
      tick();
    end
    n_checks++; if (dout_valid !== 1'b0 || empty !== 1'b1 || raddr !== 4'd3) begin n_fail++; $display("FAIL bp_done got valid=%0b empty=%0b raddr=%0d exp 0/1/3", dout_valid, empty, raddr); end
  endtask

  task automatic test_drain_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h40 + 8'(i);
    rsync_ptr2 = 5'b11000;
    tick();
    n_checks++; if (empty !== 1'b0 || rd_count !== 5'd16) begin n_fail++; $display("FAIL drain_start got empty=%0b count=%0d exp 0/16", empty, rd_count); end
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    n_checks++; if (almost_empty !== 1'b0) begin n_fail++; $display("FAIL drain_ae got %0b exp 0", almost_empty); end
`endif
    for (int i = 0; i < 16; i++) begin
      tick();
      n_checks++;
      if (dout_valid !== 1'b1 || dout !== 8'h40 + 8'(i)) begin
        n_fail++; $display("FAIL drain_word%0d got valid=%0b dout=%h exp 1/%h", i, dout_valid, dout, 8'h40 + 8'(i));
      end
    end
    n_checks++; if (rptr !== 5'b11000 || raddr !== 4'd0) begin n_fail++; $display("FAIL wrap_ptr got rptr=%b raddr=%0d exp 11000/0", rptr, raddr); end
    n_checks++; if (empty !== 1'b1 || rd_count !== 5'd0) begin n_fail++; $display("FAIL wrap_empty got empty=%0b count=%0d exp 1/0", empty, rd_count); end
    mem[0] = 8'hC3;
    rsync_ptr2 = 5'b11001;
    tick();
    n_checks++; if (empty !== 1'b0 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL lap2_edge1 got empty=%0b valid=%0b exp 0/0", empty, dout_valid); end
    tick();
    n_checks++; if (dout_valid !== 1'b1 || dout !== 8'hC3) begin n_fail++; $display("FAIL lap2_dout got valid=%0b dout=%h exp 1/c3", dout_valid, dout); end
    n_checks++; if (rptr !== 5'b11001 || raddr !== 4'd1 || empty !== 1'b1) begin n_fail++; $display("FAIL lap2_ptr got rptr=%b raddr=%0d empty=%0b exp 11001/1/1", rptr, raddr, empty); end
  endtask

  task automatic test_reset_mid_drain();
    int seen;
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h80 + 8'(i);
    rsync_ptr2 = 5'b01111;
    tick();
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (dout !== 8'h84 || raddr !== 4'd5) begin n_fail++; $display("FAIL mid_before got dout=%h raddr=%0d exp 84/5", dout, raddr); end
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    n_checks++; if (almost_empty !== 1'b0) begin n_fail++; $display("FAIL mid_ae got %0b exp 0", almost_empty); end
`endif
    #2;
    rst_n = 1'b1;
    rsync_ptr2 = 5'b00000;
    #1;
    n_checks++; if (dout_valid !== 1'b0 || dout !== 8'h00 || empty !== 1'b1) begin n_fail++; $display("FAIL mid_rst_out got valid=%0b dout=%h empty=%0b exp 0/00/1", dout_valid, dout, empty); end
    n_checks++; if (rptr !== 5'd0 || raddr !== 4'd0 || rd_count !== 5'd0) begin n_fail++; $display("FAIL mid_rst_ptr got rptr=%b raddr=%0d count=%0d exp 0/0/0", rptr, raddr, rd_count); end
    tick();
    rst_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dout_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_no_redeliver got %0d words exp 0", seen); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_single_word();
    test_backpressure();
    test_drain_wrap();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side control stage of the async FIFO, clocked in the read domain.
- Consumes the write-domain gray pointer after it has been synchronised into r_clk.
- Generates the read address, read gray pointer and empty flag.
- Presents FIFO data to the downstream consumer through a first-word-fall-through output register with a valid/ready handshake.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, FIFO entries; must be a power of two and at least 4. AW = $clog2(DEPTH).

Ports:
- r_clk  in  1  read-domain clock.
- rst_n  in  1  asynchronous, active-high reset: asserted when 1, acts immediately, released synchronously to r_clk by the top level.
- rsync_ptr2  in  AW+1  write gray pointer after the 2-flop synchroniser.
- rdata_mem  in  WIDTH  memory read data; combinational function of raddr (asynchronous-read memory).
- raddr  out  AW  memory read address.
- rptr  out  AW+1  read gray pointer, sent to the write-domain synchroniser.
- empty  out  1  FIFO memory empty, registered.
- dout  out  WIDTH  output data.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  consumer accepts dout this cycle.
- rd_count  out  AW+1  words held in memory and not yet popped, registered.

Behaviour:
- Reset values: rbin=0, rptr=0, raddr=0, empty=1, dout=0, dout_valid=0, rd_count=0.
- Reset mid-operation: all state clears immediately and any word held in dout is discarded.
- Pointer path:
  - rbin is an (AW+1)-bit binary counter; raddr = rbin[AW-1:0].
  - pop = ~empty & (~dout_valid | dout_ready).
  - rbinnext = rbin + pop, wrapping modulo 2^(AW+1).
  - rgraynext = (rbinnext>>1) ^ rbinnext.
  - On each edge: rbin<=rbinnext, rptr<=rgraynext, empty<=(rgraynext==rsync_ptr2).
- Output stage: a two-state FSM.
  - EMPTY_OUT (dout_valid=0): on pop, dout<=rdata_mem and go to VALID_OUT.
  - VALID_OUT (dout_valid=1):
    - dout_ready & pop: dout<=rdata_mem, stay in VALID_OUT (back-to-back, one word per cycle).
    - dout_ready & ~pop: go to EMPTY_OUT; dout keeps its old value.
    - ~dout_ready: dout is held stable and no pop occurs.
- Latency: if rsync_ptr2 changes before edge k, empty falls after edge k, pop happens at edge k+1, and dout_valid is 1 after edge k+1 (2 cycles).
- Throughput: 1 word per cycle while data is available and dout_ready=1.
- rd_count:
  - wbin_sync = gray2bin(rsync_ptr2).
  - rd_count <= (wbin_sync - rbinnext) mod 2^(AW+1).
  - Never exceeds DEPTH when the inputs are legal.
- Wrap-around: after 2^(AW+1) pops, rbin returns to 0; the MSB distinguishes laps.
- empty must never be derived from rd_count; gray equality is authoritative.
- rsync_ptr2 is sampled only; no further synchronisation happens inside this block.

Optional Feature:
- Macro: FIFO_RD_ALMOST_EMPTY_EN.
- Defined:
  - Adds parameter AE_LEVEL (default 2) and output almost_empty (1 bit).
  - almost_empty <= (rd_count_next <= AE_LEVEL), registered; reset value 1.
- Undefined: no port and no logic; the module interface omits almost_empty.

Decomposition:
- Shared package fifo_pkg:
  - AW-derived localparams.
  - Typedefs ptr_t (logic [AW:0]) and addr_t (logic [AW-1:0]).
  - Output FSM enum rd_state_e {EMPTY_OUT, VALID_OUT}.
  - Function bin2gray.
- Sub-module gray2bin: parameterised purely combinational gray-to-binary converter (prefix XOR). Reusable by the write side for its own occupancy count.

Test Plan:
- Reset: assert rst_n=1 mid-cycle -> empty=1, dout_valid=0, rptr=0, raddr=0 and rd_count=0 immediately, without waiting for an r_clk edge.
- Single word: rsync_ptr2 changes 00000->00001, rdata_mem[0]=8'hA5, dout_ready=1 -> empty=0 after 1 edge; dout_valid=1 with dout=8'hA5 and rptr=00001 after 2 edges; dout_valid=0 the following cycle.
- Backpressure: 3 words available, dout_ready=0 for 5 cycles -> dout held at the first word, raddr stays at 1. Release dout_ready -> 3 words delivered in 3 consecutive cycles.
- Full drain and wrap: rsync_ptr2=11000 (gray of 16) from reset, dout_ready=1 -> 16 words in 16 consecutive cycles, ending with rptr=11000, raddr=0, empty=1, rd_count=0.
- Second lap: then rsync_ptr2 advances through gray 17 (11001) -> empty falls; next pop reads raddr=0 and rptr becomes 11001.
- Reset mid-drain: rst_n=1 after 5 of 10 words -> all outputs return to reset values; the remaining words are not delivered. With FIFO_RD_ALMOST_EMPTY_EN, almost_empty=1 while rd_count<=2.
